// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-port arbiter and access sequencer for a single-port synchronous RAM
module ram_arbiter #(
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 32,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              busy,
  output logic              grant_id,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state;
  logic                last_grant;
  logic                cur_we;
  logic                elig0;
  logic                elig1;
  logic                pick;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // A port in its own ack cycle is not eligible, so a held-over req is not re-served.
  always_comb begin
    elig0 = req0 && !ack0;
    elig1 = req1 && !ack1;
    pick  = 1'b0;
    if (elig0 && elig1) begin
      pick = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant;
    end else if (elig1) begin
      pick = 1'b1;
    end
    sel_we    = pick ? we1    : we0;
    sel_addr  = pick ? addr1  : addr0;
    sel_wdata = pick ? wdata1 : wdata0;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cur_we      <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      busy        <= 1'b0;
      grant_id    <= 1'b0;
      ram_read    <= 1'b0;
      ram_write   <= 1'b0;
      ram_address <= '0;
      ram_data_in <= '0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (elig0 || elig1) begin
            grant_id    <= pick;
            last_grant  <= pick;
            cur_we      <= sel_we;
            ram_address <= sel_addr;
            ram_data_in <= sel_wdata;
            ram_read    <= !sel_we;
            ram_write   <= sel_we;
            busy        <= 1'b1;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          ram_read  <= 1'b0;
          ram_write <= 1'b0;
          state     <= RESP;
        end
        RESP: begin
          // RAM output is registered, so read data is valid one cycle after the strobe.
          if (!cur_we) begin
            if (grant_id) rdata1 <= ram_data_out;
            else          rdata0 <= ram_data_out;
          end
          if (grant_id) ack1 <= 1'b1;
          else          ack0 <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
